// File: rtl/exc_int_ctrl.sv
// Exception/interrupt sequencer between writeback and the CSR file.
// Owns the constant timer, builds ESTAT.IS and drives registered commit strobes plus a pipeline flush.
module exc_int_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMER_W      = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wb_valid,
  input  logic               wb_ex_req,
  input  logic [5:0]         wb_ecode_in,
  input  logic [8:0]         wb_esubcode_in,
  input  logic [31:0]        wb_pc_in,
  input  logic               wb_ertn,
  input  logic [7:0]         hw_int,
  input  logic               ipi_int,
  input  logic [1:0]         sw_is,
  input  logic               crmd_ie,
  input  logic [12:0]        ecfg_lie,
  input  logic               tcfg_we,
  input  logic [31:0]        tcfg_wdata,
  input  logic               ticlr_we,
  input  logic [31:0]        ticlr_wdata,
  output logic [TIMER_W-1:0] tval,
  output logic [31:0]        tcfg_rdata,
  output logic [12:0]        estat_is,
  output logic               csr_wb_ex,
  output logic [5:0]         csr_ecode,
  output logic [8:0]         csr_esubcode,
  output logic [31:0]        csr_ex_pc,
  output logic               csr_ertn_flush,
  output logic               pipe_flush,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, STROBE, DRAIN} state_t;

  state_t      state, state_next;
  logic [3:0]  flush_cnt, flush_cnt_next;
  logic [31:0] tcfg;
  logic        timer_is;
  logic        timer_set;
  logic        int_take;
  logic        accept;
  logic        unused_ticlr;

  assign unused_ticlr = ^ticlr_wdata[31:1];

  assign tcfg_rdata = tcfg;
  assign estat_is   = {ipi_int, timer_is, 1'b0, hw_int, sw_is};
  assign int_take   = crmd_ie & (|(estat_is & ecfg_lie));
  assign accept     = (state == IDLE) & wb_valid & (int_take | wb_ex_req | wb_ertn);
  assign timer_set  = ~tcfg_we & tcfg[0] & (tval == TIMER_W'(1));
  assign pipe_flush = (state != IDLE);
  assign busy       = (state != IDLE);

  // Constant timer: a TCFG write reloads and overrides counting; one-shot expiry drops En.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg <= '0;
      tval <= '0;
    end else if (tcfg_we) begin
      tcfg <= tcfg_wdata;
      tval <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
    end else if (tcfg[0] && tval != '0) begin
      tval <= tval - TIMER_W'(1);
      if (tval == TIMER_W'(1) && !tcfg[1]) tcfg[0] <= 1'b0;
    end else if (tcfg[0] && tcfg[1]) begin
      tval <= {tcfg[TIMER_W-1:2], 2'b00};
    end
  end

  // A set in the same cycle as a TICLR clear keeps the interrupt pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          timer_is <= 1'b0;
    else if (timer_set)                   timer_is <= 1'b1;
    else if (ticlr_we && ticlr_wdata[0])  timer_is <= 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // DRAIN leaves when the counter is on its last cycle so the flush spans exactly FLUSH_CYCLES.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      IDLE: if (accept) state_next = STROBE;
      STROBE: begin
        flush_cnt_next = 4'(FLUSH_CYCLES - 1);
        state_next     = (FLUSH_CYCLES > 1) ? DRAIN : IDLE;
      end
      DRAIN: begin
        flush_cnt_next = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csr_wb_ex      <= 1'b0;
      csr_ertn_flush <= 1'b0;
      csr_ecode      <= '0;
      csr_esubcode   <= '0;
      csr_ex_pc      <= '0;
    end else begin
      csr_wb_ex      <= accept & (int_take | wb_ex_req);
      csr_ertn_flush <= accept & ~int_take & ~wb_ex_req & wb_ertn;
      if (accept) begin
        csr_ex_pc <= wb_pc_in;
        if (int_take) begin
          csr_ecode    <= 6'h00;
          csr_esubcode <= 9'h000;
        end else begin
          csr_ecode    <= wb_ecode_in;
          csr_esubcode <= wb_esubcode_in;
        end
      end
    end
  end

endmodule
